// File: rtl/hazard_pkg.sv
// Shared encodings and the shadow-pipeline entry type for the hazard scoreboard.
// Entry field widths follow the default AW/TW; the top must be built with matching widths.
package hazard_pkg;

  localparam int AW_DEF = 5;
  localparam int TW_DEF = 2;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_t;

  typedef struct packed {
    logic              valid;
    logic [AW_DEF-1:0] wa;
    logic [TW_DEF-1:0] rem;
  } shadow_t;

endpackage

// File: rtl/md_busy_counter.sv
// Multi-cycle mult/div busy counter: loads on start, counts down to zero, busy while nonzero.
module md_busy_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] load_val,
  output logic         busy
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Stateful hazard unit: E/M/W shadow pipeline of in-flight writes counting down to readiness,
// decode-stall and forwarding-select logic, mult/div busy tracking and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int TW       = TW_DEF,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_valid,
  input  logic [AW-1:0]    d_rs,
  input  logic [AW-1:0]    d_rt,
  input  logic             d_use_rs,
  input  logic             d_use_rt,
  input  logic [TW-1:0]    d_tuse_rs,
  input  logic [TW-1:0]    d_tuse_rt,
  input  logic             d_wr,
  input  logic [AW-1:0]    d_wa,
  input  logic [TW-1:0]    d_tnew,
  input  logic             d_md_start,
  input  logic             d_md_div,
  input  logic             d_md_access,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_rs,
  output logic [1:0]       fwd_rt,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MD_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  typedef struct packed {
    logic hazard;
    fwd_t fwd;
  } lookup_t;

  shadow_t ent_p0;
  shadow_t ent_p1;
  shadow_t ent_p2;
  shadow_t ent_nxt;
  lookup_t lk_rs;
  lookup_t lk_rt;
  logic    issue;
  logic    md_start;
  logic [MD_W-1:0] md_load;

  function automatic shadow_t age_entry(input shadow_t s);
    shadow_t r;
    r = s;
    if (s.rem != '0) r.rem = s.rem - 1'b1;
    return r;
  endfunction

  // Youngest matching producer wins; register 0 and unused operands never match.
  function automatic lookup_t lookup(input logic use_op, input logic [AW-1:0] ra,
                                     input logic [TW-1:0] tuse, input shadow_t e,
                                     input shadow_t m, input shadow_t w);
    lookup_t r;
    r.hazard = 1'b0;
    r.fwd    = FWD_RF;
    if (use_op && ra != '0) begin
      if (e.valid && e.wa == ra) begin
        r.fwd    = FWD_E;
        r.hazard = (e.rem > tuse);
      end else if (m.valid && m.wa == ra) begin
        r.fwd    = FWD_M;
        r.hazard = (m.rem > tuse);
      end else if (w.valid && w.wa == ra) begin
        r.fwd    = FWD_W;
        r.hazard = (w.rem > tuse);
      end
    end
    return r;
  endfunction

  always_comb begin
    lk_rs = lookup(d_use_rs, d_rs, d_tuse_rs, ent_p0, ent_p1, ent_p2);
    lk_rt = lookup(d_use_rt, d_rt, d_tuse_rt, ent_p0, ent_p1, ent_p2);
  end

  assign stall  = d_valid & ~flush & (lk_rs.hazard | lk_rt.hazard | (d_md_access & md_busy));
  assign fwd_rs = lk_rs.fwd;
  assign fwd_rt = lk_rt.fwd;
  assign issue  = d_valid & ~stall & ~flush;

  always_comb begin
    ent_nxt       = '0;
    ent_nxt.valid = issue & d_wr & (d_wa != '0);
    ent_nxt.wa    = d_wa;
    ent_nxt.rem   = d_tnew;
  end

  // Shadow pipeline advances every cycle regardless of stall; only valid bits need reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_p0.valid <= 1'b0;
      ent_p1.valid <= 1'b0;
      ent_p2.valid <= 1'b0;
    end else begin
      ent_p0 <= ent_nxt;
      ent_p1 <= age_entry(ent_p0);
      ent_p2 <= age_entry(ent_p1);
    end
  end

  assign md_start = issue & d_md_start;
  assign md_load  = d_md_div ? MD_W'(DIV_CYC) : MD_W'(MULT_CYC);

  md_busy_counter #(
    .W (MD_W)
  ) u_md (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (md_start),
    .load_val (md_load),
    .busy     (md_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against an age-based in-flight write model.
module tb_hazard_scoreboard;

  localparam int CW   = 6;
  localparam int MULC = 5;
  localparam int DIVC = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          d_valid, d_use_rs, d_use_rt, d_wr, d_md_start, d_md_div, d_md_access, flush;
  logic [4:0]    d_rs, d_rt, d_wa;
  logic [1:0]    d_tuse_rs, d_tuse_rt, d_tnew;
  logic          stall, md_busy;
  logic [1:0]    fwd_rs, fwd_rt;
  logic [CW-1:0] stall_cnt;

  hazard_scoreboard #(
    .NREG(32), .AW(5), .TW(2), .MULT_CYC(MULC), .DIV_CYC(DIVC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wr(d_wr), .d_wa(d_wa), .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .d_md_access(d_md_access), .flush(flush), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: producers indexed by age in cycles since issue (0 = in E, 1 = M, 2 = W).
  bit         h_v[3];
  logic [4:0] h_wa[3];
  int         h_tnew[3];
  int         now, md_end, m_cnt;
  bit         exp_stall, exp_busy;
  int         exp_fwd_rs, exp_fwd_rt;
  logic       obs_stall, obs_busy;
  logic [1:0] obs_fwd_rs, obs_fwd_rt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void lookup(input logic use_op, input logic [4:0] ra, input int tuse,
                                 output bit hz, output int fw);
    int rem;
    hz = 0;
    fw = 0;
    if (use_op && ra != 0) begin
      for (int a = 0; a < 3; a++) begin
        if (h_v[a] && h_wa[a] == ra) begin
          rem = (h_tnew[a] > a) ? h_tnew[a] - a : 0;
          hz  = (rem > tuse);
          fw  = a + 1;
          break;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int a = 0; a < 3; a++) h_v[a] = 0;
    now = 0;
    md_end = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_eval();
    bit hzs, hzt;
    lookup(d_use_rs, d_rs, int'(d_tuse_rs), hzs, exp_fwd_rs);
    lookup(d_use_rt, d_rt, int'(d_tuse_rt), hzt, exp_fwd_rt);
    exp_busy  = (now < md_end);
    exp_stall = d_valid && !flush && (hzs || hzt || (d_md_access && exp_busy));
  endfunction

  function automatic void model_step();
    bit iss;
    iss = d_valid && !exp_stall && !flush;
    for (int a = 2; a > 0; a--) begin
      h_v[a] = h_v[a-1];
      h_wa[a] = h_wa[a-1];
      h_tnew[a] = h_tnew[a-1];
    end
    h_v[0] = iss && d_wr && (d_wa != 0);
    h_wa[0] = d_wa;
    h_tnew[0] = int'(d_tnew);
    now++;
    if (iss && d_md_start) md_end = now + (d_md_div ? DIVC : MULC);
    if (exp_stall && m_cnt < (1 << CW) - 1) m_cnt++;
  endfunction

  task automatic clear_in();
    d_valid = 0; d_use_rs = 0; d_use_rt = 0; d_wr = 0; d_md_start = 0; d_md_div = 0;
    d_md_access = 0; flush = 0; d_rs = 0; d_rt = 0; d_wa = 0;
    d_tuse_rs = 0; d_tuse_rt = 0; d_tnew = 0;
  endtask

  // Inputs are set just after a rising edge; outputs are sampled on the falling edge.
  task automatic cycle();
    @(negedge clk);
    model_eval();
    obs_stall = stall; obs_busy = md_busy; obs_fwd_rs = fwd_rs; obs_fwd_rt = fwd_rt;
    check("stall", stall, exp_stall);
    if (!exp_stall) begin
      check("fwd_rs", fwd_rs, exp_fwd_rs);
      check("fwd_rt", fwd_rt, exp_fwd_rt);
    end
    check("md_busy", md_busy, exp_busy);
    check("stall_cnt", stall_cnt, m_cnt);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  int n, k;

  initial begin
    clear_in();
    model_reset();
    #3;
    check("rst_stall", stall, 0);
    check("rst_fwd_rs", fwd_rs, 0);
    check("rst_busy", md_busy, 0);
    check("rst_cnt", stall_cnt, 0);
    do_reset();

    // Load-use
    d_valid = 1; d_wr = 1; d_wa = 8; d_tnew = 2; cycle();
    clear_in(); d_valid = 1; d_use_rs = 1; d_rs = 8; d_tuse_rs = 1;
    cycle(); check("lu_stall", obs_stall, 1);
    cycle(); check("lu_nostall", obs_stall, 0); check("lu_fwd", obs_fwd_rs, 2);
    check("lu_cnt", stall_cnt, 1);

    // Branch after ALU
    do_reset();
    d_valid = 1; d_wr = 1; d_wa = 9; d_tnew = 1; cycle();
    clear_in(); d_valid = 1; d_use_rs = 1; d_rs = 9; d_tuse_rs = 0;
    cycle(); check("br_stall", obs_stall, 1);
    cycle(); check("br_nostall", obs_stall, 0); check("br_fwd", obs_fwd_rs, 2);

    // Youngest producer wins, on both operands
    do_reset();
    d_valid = 1; d_wr = 1; d_wa = 10; d_tnew = 0; cycle(); cycle();
    clear_in(); d_valid = 1; d_use_rs = 1; d_rs = 10; d_use_rt = 1; d_rt = 10;
    cycle(); check("yw_stall", obs_stall, 0); check("yw_fwd_rs", obs_fwd_rs, 1);
    check("yw_fwd_rt", obs_fwd_rt, 1);

    // Mult followed by mflo
    do_reset();
    d_valid = 1; d_md_start = 1; d_md_access = 1; cycle();
    check("mul_busy_rise", md_busy, 1);
    clear_in(); d_valid = 1; d_md_access = 1;
    n = 0; k = 0;
    do begin
      cycle();
      if (obs_stall) n++;
      k++;
    end while (obs_stall && k < 20);
    check("mul_stalls", n, MULC);
    check("mul_busy_fall", obs_busy, 0);
    check("mul_cnt", stall_cnt, MULC);

    // Register 0 and flush
    do_reset();
    d_valid = 1; d_wr = 1; d_wa = 0; d_tnew = 2; cycle();
    clear_in(); d_valid = 1; d_use_rs = 1; d_rs = 0;
    cycle(); check("r0_stall", obs_stall, 0); check("r0_fwd", obs_fwd_rs, 0);
    clear_in(); d_valid = 1; d_wr = 1; d_wa = 8; d_tnew = 2; flush = 1; cycle();
    clear_in(); d_valid = 1; d_use_rs = 1; d_rs = 8;
    cycle(); check("fl_stall", obs_stall, 0); check("fl_fwd", obs_fwd_rs, 0);
    clear_in(); d_valid = 1; d_wr = 1; d_wa = 8; d_tnew = 2; cycle();
    clear_in(); d_valid = 1; d_use_rs = 1; d_rs = 8; flush = 1;
    cycle(); check("fl_hazard_stall", obs_stall, 0);

    // Reset during the third busy cycle of a div
    do_reset();
    d_valid = 1; d_md_start = 1; d_md_div = 1; d_md_access = 1; cycle();
    clear_in(); d_valid = 1; d_md_access = 1;
    cycle(); cycle();
    check("div_busy_pre", md_busy, 1);
    rst_n = 0;
    model_reset();
    #1;
    check("mr_busy", md_busy, 0);
    check("mr_stall", stall, 0);
    check("mr_cnt", stall_cnt, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    cycle(); check("mr_mflo_stall", obs_stall, 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      d_valid     = ($urandom_range(9) != 0);
      d_rs        = 5'($urandom_range(3));
      d_rt        = 5'($urandom_range(3));
      d_use_rs    = 1'($urandom_range(1));
      d_use_rt    = 1'($urandom_range(1));
      d_tuse_rs   = 2'($urandom_range(3));
      d_tuse_rt   = 2'($urandom_range(3));
      d_wr        = 1'($urandom_range(1));
      d_wa        = 5'($urandom_range(3));
      d_tnew      = 2'($urandom_range(2));
      d_md_start  = ($urandom_range(15) == 0);
      d_md_div    = 1'($urandom_range(1));
      d_md_access = d_md_start | ($urandom_range(5) == 0);
      flush       = ($urandom_range(9) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
